proj_to_affine: RTL
===================

# proj_to_affine

Converts a projective point (X:Y:Z) over GF(p), p = 2^255 − 19, into affine coordinates x = X·Z⁻¹ mod p and y = Y·Z⁻¹ mod p. It sits directly downstream of ScalarMul and consumes its o_x/o_y/o_z result once o_finished rises. Z⁻¹ is computed by Fermat exponentiation (Z^(p−2)) on a single bit-serial interleaved modular multiplier shared by all multiplications. The design targets minimum area, not throughput.

## Interface
- P_MOD, 255'h7fff…ffed (2^255 − 19), field modulus
- i_clk  in  1  clock, all state updates on the rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle start pulse; sampled only in IDLE or DONE
- i_x  in  255  projective X, canonical (< p)
- i_y  in  255  projective Y, canonical (< p)
- i_z  in  255  projective Z, canonical (< p)
- o_x  out  255  affine x, registered
- o_y  out  255  affine y, registered
- o_finished  out  1  level: result valid; held until the next accepted i_start
- o_error  out  1  level, valid with o_finished: Z was 0, so no affine point exists

## Operation
- States: IDLE → CHECK → INV → MULX → MULY → DONE; from DONE, i_start → CHECK.
- Start in IDLE/DONE: capture i_x, i_y, i_z; clear o_finished, o_error, o_x, o_y; go to CHECK.
- CHECK (1 cycle): if Z == 0, set o_error = 1, o_x = o_y = 0, and go to DONE; otherwise acc = 1 and exponent index e = 254, then go to INV.
- INV: left-to-right square-and-multiply over E = p − 2 = 2^255 − 21 (bits 254..5 = 1; bits 4..0 = 01011).
  - Per bit: acc = acc² mod p; if E[e] = 1, then acc = acc·Z mod p.
  - Totals: 255 squarings and 253 multiplies, 508 multiplications.
- MULX: o_x ← X·acc mod p. MULY: o_y ← Y·acc mod p. Then DONE with o_finished = 1 and o_error = 0.
- Multiplier (a·b mod p), interleaved MSB-first:
  - 1 load cycle: r = 0, bit pointer = 254.
  - Then 255 iteration cycles: r = 2r + (b[i] ? a : 0), followed by up to two conditional subtractions of p in the same cycle (intermediate < 3p, 257-bit datapath).
  - Result r < p always.
  - 256 cycles per multiplication.
- i_start in CHECK/INV/MULX/MULY: ignored; the operation continues undisturbed.
- Output registers are written only at the end of MULX/MULY or CHECK (error case). Intermediate acc values are never visible on o_x/o_y.

## Timing
- Reset (async assert, any state): state = IDLE; o_x = 0, o_y = 0, o_finished = 0, o_error = 0; all internal registers = 0. Release is synchronous to i_clk.
- Reset mid-operation aborts with no output; a new i_start is required afterwards.
- Normal latency: the edge sampling i_start is cycle 0. CHECK occupies cycle 1. There are 510 multiplications × 256 cycles. o_finished rises on the edge ending cycle 1 + 130,560 + 1 = 130,562.
- Z == 0 latency: o_finished and o_error rise 2 cycles after the start edge.
- o_finished, o_error, o_x and o_y change only on an accepted start (cleared), at completion, or on reset.
- Back-to-back: i_start in the same cycle o_finished is high is accepted. o_finished drops on the next edge.
- Inputs need only be stable on the start edge; later changes have no effect.

## Test plan
- Z = 1, X = 0x1234, Y = p − 1 → o_x = 0x1234, o_y = p − 1, o_error = 0, o_finished at exactly cycle 130,562.
- Z = 2, X = 2, Y = 4 → o_x = 1, o_y = 2. Then Z = p − 1, X = 5, Y = 7 → o_x = p − 5, o_y = p − 7.
- Identity (0:1:1), then (0:3:3) → (0, 1) both times; o_error = 0.
- Z = 0, X = Y = 9 → o_error = 1, o_x = o_y = 0, o_finished at cycle 2.
- Chain after ScalarMul: feed its (o_x, o_y, o_z) for X = 0fa4…2fae, Y = 2f0f…bea2, M = 259f…216a. Require o_x·Z ≡ X and o_y·Z ≡ Y (mod p), checked by a bench model.
- Control corners:
  - i_start pulsed at cycle 1,000 mid-run → ignored; result unchanged.
  - i_rst_n low at cycle 50,000 → all outputs 0 immediately; a subsequent start completes correctly.

Source files
------------

// File: rtl/proj_to_affine.sv
// Projective (X:Y:Z) to affine (x, y) over GF(2^255-19).
// Z^-1 = Z^(p-2) by square-and-multiply on a single shared bit-serial modular multiplier.
//
// state | meaning
// IDLE  | waiting for i_start after reset
// CHECK | reject Z == 0, otherwise seed the exponentiation
// INV   | acc <- Z^(p-2), one square (+ optional multiply by Z) per exponent bit
// MULX  | o_x <- X * acc
// MULY  | o_y <- Y * acc
// DONE  | result held; i_start begins a new conversion
module proj_to_affine #(
  parameter logic [254:0] P_MOD = 255'((256'd1 << 255) - 256'd19)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [254:0] i_x,
  input  logic [254:0] i_y,
  input  logic [254:0] i_z,
  output logic [254:0] o_x,
  output logic [254:0] o_y,
  output logic         o_finished,
  output logic         o_error
);

  localparam logic [254:0] EXP = P_MOD - 255'd2;
  localparam logic [256:0] P_W = {2'b00, P_MOD};

  typedef enum logic [2:0] {IDLE, CHECK, INV, MULX, MULY, DONE} state_t;

  state_t       state;
  logic [254:0] x_q, y_q, z_q, acc, r;
  logic [7:0]   ptr, e_idx;
  logic         mul_load, mul_sq, fin_pend, err_pend;

  logic [254:0] op_a, op_b, r_next;
  logic [256:0] t0, t1;
  logic         last_op;

  // Operands are selected from live registers rather than latched; acc only
  // changes at the end of a multiplication, so they are stable throughout.
  always_comb begin
    op_a = acc;
    op_b = acc;
    case (state)
      MULX:    op_a = x_q;
      MULY:    op_a = y_q;
      INV:     if (!mul_sq) op_b = z_q;
      default: ;
    endcase
    t0 = {1'b0, r, 1'b0} + (op_b[ptr] ? {2'b00, op_a} : 257'd0);
    t1 = (t0 >= P_W) ? t0 - P_W : t0;
    r_next = 255'((t1 >= P_W) ? t1 - P_W : t1);
    last_op = !mul_sq || !EXP[e_idx];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      acc        <= '0;
      r          <= '0;
      ptr        <= '0;
      e_idx      <= '0;
      mul_load   <= 1'b0;
      mul_sq     <= 1'b0;
      fin_pend   <= 1'b0;
      err_pend   <= 1'b0;
      o_x        <= '0;
      o_y        <= '0;
      o_finished <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // Completion is published one cycle after entering DONE.
          if (state == DONE && fin_pend) begin
            o_finished <= 1'b1;
            o_error    <= err_pend;
            fin_pend   <= 1'b0;
          end
          if (i_start) begin
            x_q        <= i_x;
            y_q        <= i_y;
            z_q        <= i_z;
            o_x        <= '0;
            o_y        <= '0;
            o_finished <= 1'b0;
            o_error    <= 1'b0;
            fin_pend   <= 1'b0;
            err_pend   <= 1'b0;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (z_q == '0) begin
            err_pend <= 1'b1;
            fin_pend <= 1'b1;
            state    <= DONE;
          end else begin
            acc      <= 255'd1;
            e_idx    <= 8'd254;
            mul_sq   <= 1'b1;
            mul_load <= 1'b1;
            state    <= INV;
          end
        end
        INV, MULX, MULY: begin
          if (mul_load) begin
            r        <= '0;
            ptr      <= 8'd254;
            mul_load <= 1'b0;
          end else begin
            r   <= r_next;
            ptr <= ptr - 8'd1;
            if (ptr == 8'd0) begin
              mul_load <= 1'b1;
              case (state)
                INV: begin
                  acc <= r_next;
                  if (last_op) begin
                    mul_sq <= 1'b1;
                    if (e_idx == 8'd0) state <= MULX;
                    else e_idx <= e_idx - 8'd1;
                  end else begin
                    mul_sq <= 1'b0;
                  end
                end
                MULX: begin
                  o_x   <= r_next;
                  state <= MULY;
                end
                default: begin
                  o_y      <= r_next;
                  mul_load <= 1'b0;
                  fin_pend <= 1'b1;
                  state    <= DONE;
                end
              endcase
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
